// File: rtl/exec_core_pkg.sv
// Shared definitions for the exec_core decode/condition/execute datapath:
// opcode values, condition codes, instruction field positions and the
// condition evaluation helper.
package exec_core_pkg;

   // Opcodes carried in instr[13:10]
   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_NOT  = 4'h5;
   localparam logic [3:0] OP_LSL  = 4'h6;
   localparam logic [3:0] OP_LSR  = 4'h7;
   localparam logic [3:0] OP_ASR  = 4'h8;
   localparam logic [3:0] OP_MOV  = 4'h9;
   localparam logic [3:0] OP_INC  = 4'hA;
   localparam logic [3:0] OP_DEC  = 4'hB;
   localparam logic [3:0] OP_NAND = 4'hC;
   localparam logic [3:0] OP_NOR  = 4'hD;
   localparam logic [3:0] OP_CMP  = 4'hE;
   localparam logic [3:0] OP_NOP  = 4'hF;

   // Condition codes carried in instr[15:14]
   localparam logic [1:0] CC_AL = 2'b00;
   localparam logic [1:0] CC_EQ = 2'b01;
   localparam logic [1:0] CC_NE = 2'b10;
   localparam logic [1:0] CC_MI = 2'b11;

   // Instruction field bit positions (msb/lsb)
   localparam int COND_MSB  = 15;
   localparam int COND_LSB  = 14;
   localparam int OP_MSB    = 13;
   localparam int OP_LSB    = 10;
   localparam int DEST_MSB  = 9;
   localparam int DEST_LSB  = 7;
   localparam int SRC1_MSB  = 6;
   localparam int SRC1_LSB  = 4;
   localparam int SRC2_MSB  = 3;
   localparam int SRC2_LSB  = 1;
   localparam int SHAMT_MSB = 3;
   localparam int SHAMT_LSB = 0;

   // Decide whether an instruction with condition code cc may execute
   function automatic logic cond_met(input logic [1:0] cc, input logic n, input logic z);
      logic met;
      met = 1'b0;
      case (cc)
         CC_AL:   met = 1'b1;
         CC_EQ:   met = z;
         CC_NE:   met = ~z;
         CC_MI:   met = n;
         default: met = 1'b0;
      endcase
      return met;
   endfunction

endpackage

// File: rtl/exec_core_alu.sv
// Combinational 16-bit ALU for exec_core. Produces the result and the
// candidate N/Z/V/C flags; the caller decides whether the flags are kept.
import exec_core_pkg::*;

module exec_alu (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [3:0]  op,
   input  logic [4:0]  shamt,
   output logic [15:0] result,
   output logic        nf,
   output logic        zf,
   output logic        vf,
   output logic        cf
);

   logic [15:0]        addend;
   logic [16:0]        add_sum;
   logic [16:0]        sub_diff;
   logic               add_v;
   logic               sub_v;
   logic [16:0]        lsl_w;
   logic [16:0]        lsr_w;
   logic signed [16:0] asr_w;

   // INC/DEC reuse the adder and subtractor with a constant one as operand B
   always_comb begin
      addend   = (op == OP_INC || op == OP_DEC) ? 16'd1 : b;
      add_sum  = {1'b0, a} + {1'b0, addend};
      sub_diff = {1'b0, a} - {1'b0, addend};
      add_v    = (a[15] == addend[15]) && (add_sum[15] != a[15]);
      sub_v    = (a[15] != addend[15]) && (sub_diff[15] != a[15]);
      // One extra bit on the shifted side catches the last bit shifted out (0 when shamt is 0)
      lsl_w    = {1'b0, a} << shamt;
      lsr_w    = {a, 1'b0} >> shamt;
      asr_w    = $signed({a, 1'b0}) >>> shamt;
   end

   // Select the result and the carry/overflow for the current opcode
   always_comb begin
      result = 16'h0000;
      cf     = 1'b0;
      vf     = 1'b0;
      case (op)
         OP_ADD, OP_INC: begin
            result = add_sum[15:0];
            cf     = add_sum[16];
            vf     = add_v;
         end
         OP_SUB, OP_DEC, OP_CMP: begin
            result = sub_diff[15:0];
            cf     = ~sub_diff[16];
            vf     = sub_v;
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOT:  result = ~a;
         OP_LSL: begin
            result = lsl_w[15:0];
            cf     = lsl_w[16];
         end
         OP_LSR: begin
            result = lsr_w[16:1];
            cf     = lsr_w[0];
         end
         OP_ASR: begin
            result = asr_w[16:1];
            cf     = asr_w[0];
         end
         OP_MOV:  result = a;
         OP_NAND: result = ~(a & b);
         OP_NOR:  result = ~(a | b);
         default: result = 16'h0000;
      endcase
      nf = result[15];
      zf = (result == 16'h0000);
   end

endmodule

// File: rtl/exec_core.sv
// Decode/condition/execute datapath of the 3-state CPU. Slices the
// instruction into register selects, latches the condition outcome in
// DECODE, drives the register-file write in EXECUTE and holds the flags.
import exec_core_pkg::*;

module exec_core #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] instr,
   input  logic             dec_en,
   input  logic             exec_en,
   input  logic [WIDTH-1:0] rs1_data,
   input  logic [WIDTH-1:0] rs2_data,
   output logic [2:0]       dest_sel,
   output logic [2:0]       src1_sel,
   output logic [2:0]       src2_sel,
   output logic [WIDTH-1:0] result,
   output logic             wr_en,
   output logic             cond_pass,
   output logic             negative,
   output logic             zero,
   output logic             overflow,
   output logic             carry
);

   logic [1:0] cond;
   logic [3:0] op;
   logic [4:0] shamt;
   logic       nf;
   logic       zf;
   logic       vf;
   logic       cf;
   logic       flag_update;

   // Field slicing; the low nibble serves both as src2 and as shift amount
   always_comb begin
      cond     = instr[COND_MSB:COND_LSB];
      op       = instr[OP_MSB:OP_LSB];
      dest_sel = instr[DEST_MSB:DEST_LSB];
      src1_sel = instr[SRC1_MSB:SRC1_LSB];
      src2_sel = instr[SRC2_MSB:SRC2_LSB];
      shamt    = {1'b0, instr[SHAMT_MSB:SHAMT_LSB]};
   end

   exec_alu u_alu (
      .a      (rs1_data),
      .b      (rs2_data),
      .op     (op),
      .shamt  (shamt),
      .result (result),
      .nf     (nf),
      .zf     (zf),
      .vf     (vf),
      .cf     (cf)
   );

   // Write strobe and flag-update qualifier for the EXECUTE cycle
   always_comb begin
      wr_en       = exec_en & cond_pass & (op != OP_CMP) & (op != OP_NOP);
      flag_update = exec_en & cond_pass & (op != OP_NOP);
   end

   // Condition latch and flag registers; reset wins over both enables
   always_ff @(posedge clk) begin
      if (rst) begin
         cond_pass <= 1'b0;
         negative  <= 1'b0;
         zero      <= 1'b0;
         overflow  <= 1'b0;
         carry     <= 1'b0;
      end else begin
         if (dec_en) begin
            cond_pass <= cond_met(cond, negative, zero);
         end
         if (flag_update) begin
            negative <= nf;
            zero     <= zf;
            overflow <= vf;
            carry    <= cf;
         end
      end
   end

endmodule

// File: tb/tb_exec_core.sv
// Directed self-checking bench for exec_core: reset, arithmetic, conditions,
// shifts, compare/no-op, decode fields and reset in the middle of EXECUTE.
module tb_exec_core;

   logic        clk;
   logic        rst;
   logic [15:0] instr;
   logic        dec_en;
   logic        exec_en;
   logic [15:0] rs1_data;
   logic [15:0] rs2_data;
   logic [2:0]  dest_sel;
   logic [2:0]  src1_sel;
   logic [2:0]  src2_sel;
   logic [15:0] result;
   logic        wr_en;
   logic        cond_pass;
   logic        negative;
   logic        zero;
   logic        overflow;
   logic        carry;

   int compared   = 0;
   int mismatched = 0;

   exec_core dut (
      .clk       (clk),
      .rst       (rst),
      .instr     (instr),
      .dec_en    (dec_en),
      .exec_en   (exec_en),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .dest_sel  (dest_sel),
      .src1_sel  (src1_sel),
      .src2_sel  (src2_sel),
      .result    (result),
      .wr_en     (wr_en),
      .cond_pass (cond_pass),
      .negative  (negative),
      .zero      (zero),
      .overflow  (overflow),
      .carry     (carry)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction word builder: cond, op, dest, src1, low nibble (src2<<1 or shamt)
   function automatic logic [15:0] enc(input logic [1:0] c, input logic [3:0] o,
                                       input logic [2:0] d, input logic [2:0] s1,
                                       input logic [3:0] low);
      return {c, o, d, s1, low};
   endfunction

   // Present an instruction and its operands for one DECODE cycle
   task automatic decode_phase(input logic [15:0] i, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      instr = i; rs1_data = a; rs2_data = b;
      dec_en = 1'b1; exec_en = 1'b0;
   endtask

   // Enter the EXECUTE cycle; outputs are sampled 1 time unit later by the caller
   task automatic exec_phase();
      @(negedge clk);
      dec_en = 1'b0; exec_en = 1'b1;
      #1;
   endtask

   // Leave EXECUTE after the flag-updating edge
   task automatic end_phase();
      @(negedge clk);
      exec_en = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      compared++; if ({negative, zero, overflow, carry} !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_flags got=%b want=0000", {negative, zero, overflow, carry}); end
      compared++; if (cond_pass !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_cond_pass got=%b want=0", cond_pass); end
      compared++; if (wr_en !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_wr_en got=%b want=0", wr_en); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add();
      decode_phase(enc(2'b00, 4'h0, 3'd1, 3'd2, 4'b0110), 16'h7FFF, 16'h0001);
      #1;
      compared++; if (wr_en !== 1'b0) begin mismatched++; $display("[TB] FAIL add_wr_en_decode got=%b want=0", wr_en); end
      exec_phase();
      compared++; if (result !== 16'h8000) begin mismatched++; $display("[TB] FAIL add_result got=%h want=8000", result); end
      compared++; if (wr_en !== 1'b1) begin mismatched++; $display("[TB] FAIL add_wr_en got=%b want=1", wr_en); end
      end_phase();
      compared++; if ({negative, zero, overflow, carry} !== 4'b1010) begin mismatched++; $display("[TB] FAIL add_flags got=%b want=1010", {negative, zero, overflow, carry}); end
   endtask

   task automatic test_sub_cond();
      decode_phase(enc(2'b00, 4'h1, 3'd3, 3'd1, 4'b0100), 16'h0005, 16'h0005);
      exec_phase();
      compared++; if (result !== 16'h0000) begin mismatched++; $display("[TB] FAIL sub_result got=%h want=0000", result); end
      end_phase();
      compared++; if ({negative, zero, overflow, carry} !== 4'b0101) begin mismatched++; $display("[TB] FAIL sub_flags got=%b want=0101", {negative, zero, overflow, carry}); end
      // cond EQ with Z=1 must pass; ADD 0+0 keeps Z set
      decode_phase(enc(2'b01, 4'h0, 3'd4, 3'd1, 4'b0100), 16'h0000, 16'h0000);
      exec_phase();
      compared++; if (cond_pass !== 1'b1) begin mismatched++; $display("[TB] FAIL eq_cond_pass got=%b want=1", cond_pass); end
      compared++; if (wr_en !== 1'b1) begin mismatched++; $display("[TB] FAIL eq_wr_en got=%b want=1", wr_en); end
      end_phase();
      compared++; if ({negative, zero, overflow, carry} !== 4'b0100) begin mismatched++; $display("[TB] FAIL eq_flags got=%b want=0100", {negative, zero, overflow, carry}); end
      // cond NE with Z=1 must fail: no write, flags held
      decode_phase(enc(2'b10, 4'h0, 3'd5, 3'd1, 4'b0100), 16'h0001, 16'h0001);
      exec_phase();
      compared++; if (cond_pass !== 1'b0) begin mismatched++; $display("[TB] FAIL ne_cond_pass got=%b want=0", cond_pass); end
      compared++; if (wr_en !== 1'b0) begin mismatched++; $display("[TB] FAIL ne_wr_en got=%b want=0", wr_en); end
      compared++; if (result !== 16'h0002) begin mismatched++; $display("[TB] FAIL ne_result got=%h want=0002", result); end
      end_phase();
      compared++; if ({negative, zero, overflow, carry} !== 4'b0100) begin mismatched++; $display("[TB] FAIL ne_flags got=%b want=0100", {negative, zero, overflow, carry}); end
   endtask

   task automatic test_shifts();
      decode_phase(enc(2'b00, 4'h7, 3'd1, 3'd2, 4'd1), 16'h8001, 16'h0000);
      exec_phase();
      compared++; if (result !== 16'h4000) begin mismatched++; $display("[TB] FAIL lsr_result got=%h want=4000", result); end
      end_phase();
      compared++; if ({negative, zero, overflow, carry} !== 4'b0001) begin mismatched++; $display("[TB] FAIL lsr_flags got=%b want=0001", {negative, zero, overflow, carry}); end
      decode_phase(enc(2'b00, 4'h8, 3'd1, 3'd2, 4'd15), 16'h8000, 16'h0000);
      exec_phase();
      compared++; if (result !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL asr_result got=%h want=ffff", result); end
      end_phase();
      compared++; if ({negative, zero, overflow, carry} !== 4'b1000) begin mismatched++; $display("[TB] FAIL asr_flags got=%b want=1000", {negative, zero, overflow, carry}); end
      decode_phase(enc(2'b00, 4'h6, 3'd1, 3'd2, 4'd0), 16'h1234, 16'h0000);
      exec_phase();
      compared++; if (result !== 16'h1234) begin mismatched++; $display("[TB] FAIL lsl0_result got=%h want=1234", result); end
      end_phase();
      compared++; if ({negative, zero, overflow, carry} !== 4'b0000) begin mismatched++; $display("[TB] FAIL lsl0_flags got=%b want=0000", {negative, zero, overflow, carry}); end
      decode_phase(enc(2'b00, 4'h6, 3'd1, 3'd2, 4'd15), 16'h0001, 16'h0000);
      exec_phase();
      compared++; if (result !== 16'h8000) begin mismatched++; $display("[TB] FAIL lsl15_result got=%h want=8000", result); end
      end_phase();
      compared++; if ({negative, zero, overflow, carry} !== 4'b1000) begin mismatched++; $display("[TB] FAIL lsl15_flags got=%b want=1000", {negative, zero, overflow, carry}); end
   endtask

   task automatic test_cmp_nop();
      // Clear flags first with a MOV of a positive value
      decode_phase(enc(2'b00, 4'h9, 3'd1, 3'd2, 4'd0), 16'h0011, 16'h0000);
      exec_phase();
      end_phase();
      decode_phase(enc(2'b00, 4'hE, 3'd1, 3'd2, 4'b0110), 16'h0003, 16'h0004);
      exec_phase();
      compared++; if (wr_en !== 1'b0) begin mismatched++; $display("[TB] FAIL cmp_wr_en got=%b want=0", wr_en); end
      compared++; if (result !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL cmp_result got=%h want=ffff", result); end
      end_phase();
      compared++; if ({negative, zero, overflow, carry} !== 4'b1000) begin mismatched++; $display("[TB] FAIL cmp_flags got=%b want=1000", {negative, zero, overflow, carry}); end
      decode_phase(enc(2'b00, 4'hF, 3'd1, 3'd2, 4'b0110), 16'h0000, 16'h0000);
      exec_phase();
      compared++; if (wr_en !== 1'b0) begin mismatched++; $display("[TB] FAIL nop_wr_en got=%b want=0", wr_en); end
      end_phase();
      compared++; if ({negative, zero, overflow, carry} !== 4'b1000) begin mismatched++; $display("[TB] FAIL nop_flags got=%b want=1000", {negative, zero, overflow, carry}); end
   endtask

   task automatic test_decode();
      @(negedge clk);
      instr = 16'hFFFF; rs1_data = 16'h0102; rs2_data = 16'h0304;
      #1;
      compared++; if ({dest_sel, src1_sel, src2_sel} !== 9'o777) begin mismatched++; $display("[TB] FAIL dec_ffff_fields got=%o want=777", {dest_sel, src1_sel, src2_sel}); end
      compared++; if (wr_en !== 1'b0) begin mismatched++; $display("[TB] FAIL dec_ffff_wr_en got=%b want=0", wr_en); end
      instr = 16'h0000;
      #1;
      compared++; if ({dest_sel, src1_sel, src2_sel} !== 9'o000) begin mismatched++; $display("[TB] FAIL dec_0000_fields got=%o want=000", {dest_sel, src1_sel, src2_sel}); end
      compared++; if (result !== 16'h0406) begin mismatched++; $display("[TB] FAIL dec_0000_result got=%h want=0406", result); end
      instr = enc(2'b10, 4'h3, 3'd5, 3'd2, 4'b1100);
      #1;
      compared++; if ({dest_sel, src1_sel, src2_sel} !== 9'o526) begin mismatched++; $display("[TB] FAIL dec_mixed_fields got=%o want=526", {dest_sel, src1_sel, src2_sel}); end
   endtask

   task automatic test_reset_mid();
      // Make flags nonzero so reset visibly clears them
      decode_phase(enc(2'b00, 4'h1, 3'd1, 3'd2, 4'b0110), 16'h0003, 16'h0004);
      exec_phase();
      end_phase();
      decode_phase(enc(2'b00, 4'h0, 3'd1, 3'd2, 4'b0110), 16'h7FFF, 16'h0001);
      @(negedge clk);
      dec_en = 1'b0; exec_en = 1'b1; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      compared++; if ({negative, zero, overflow, carry} !== 4'b0000) begin mismatched++; $display("[TB] FAIL rstmid_flags got=%b want=0000", {negative, zero, overflow, carry}); end
      compared++; if (cond_pass !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_cond_pass got=%b want=0", cond_pass); end
      compared++; if (wr_en !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_wr_en got=%b want=0", wr_en); end
      @(negedge clk);
      exec_en = 1'b0;
   endtask

   // Run every scenario in order, then report
   initial begin
      rst = 1'b1; dec_en = 1'b0; exec_en = 1'b0;
      instr = 16'h0000; rs1_data = 16'h0000; rs2_data = 16'h0000;
      test_reset();
      test_add();
      test_sub_cond();
      test_shifts();
      test_cmp_nop();
      test_decode();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
